// File: rtl/fpu_issue_stage.sv
// fpu_issue_stage: 2-entry request FIFO feeding a combinational FPU, with a registered result slot.
// Optional sticky exception flags are built in when FPU_STICKY_FLAGS_EN is defined.
module fpu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  input  logic [3:0]  in_tag,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_ctrl,
  input  logic [31:0] fpu_result,
  input  logic [3:0]  fpu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  out_tag,
  input  logic        clear_sticky,
  output logic [3:0]  sticky_flags
);

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  req_t       fifo_q [2];
  req_t       head;
  req_t       in_req;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       head_half;

  assign in_req    = '{op: in_op, tag: in_tag, a: in_a, b: in_b};
  assign in_ready  = (count < 2'd2);
  assign push      = in_valid && in_ready;
  // The result slot frees up either when it is empty or when it is consumed this cycle.
  assign pop       = (count != 2'd0) && (!out_valid || out_ready);
  assign head      = fifo_q[rd_ptr];
  assign head_half = ~head.op[0];

  always_comb begin
    fpu_a    = '0;
    fpu_b    = '0;
    fpu_ctrl = '0;
    if (count != 2'd0) begin
      fpu_ctrl = head.op;
      fpu_a    = head_half ? {16'h0, head.a[15:0]} : head.a;
      fpu_b    = head_half ? {16'h0, head.b[15:0]} : head.b;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= in_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
      if (pop) begin
        out_valid  <= 1'b1;
        out_result <= head_half ? {16'h0, fpu_result[15:0]} : fpu_result;
        out_flags  <= fpu_flags;
        out_tag    <= head.tag;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef FPU_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // A clear coincident with a pop keeps only that pop's flags.
  always_ff @(posedge clk) begin
    if (!reset)            sticky_q <= '0;
    else if (pop)          sticky_q <= (clear_sticky ? 4'h0 : sticky_q) | fpu_flags;
    else if (clear_sticky) sticky_q <= '0;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_clear_sticky;

  assign unused_clear_sticky = clear_sticky;
  assign sticky_flags        = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Self-checking bench for fpu_issue_stage: directed spec vectors plus random traffic
// against a queue-based reference model; the FPU itself is a behavioural stand-in.
module tb_fpu_issue_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic [31:0] fpu_a, fpu_b, fpu_result, out_result;
  logic [1:0]  fpu_ctrl;
  logic [3:0]  fpu_flags, out_flags, out_tag, sticky_flags;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        clear_sticky = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_ctrl(fpu_ctrl),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
    .clear_sticky(clear_sticky), .sticky_flags(sticky_flags)
  );

  // Stand-in FPU: exact answers for the directed vectors, a scrambling hash otherwise.
  function automatic logic [35:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    if (c == 2'b01 && a == 32'h3F800000 && b == 32'h3F800000) return {4'h0, 32'h40000000};
    if (c == 2'b00 && a == 32'h00003E80 && b == 32'h00003800) return {4'h0, 32'hDEAD4040};
    if (c == 2'b11 && a == 32'h3FC00000 && b == 32'h3FC00000) return {4'h0, 32'h40100000};
    return {a[3:0] ^ b[3:0], (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {c, 30'd0}};
  endfunction

  always_comb {fpu_flags, fpu_result} = fpu_fn(fpu_a, fpu_b, fpu_ctrl);

  function automatic logic [31:0] lo16(input logic [31:0] v, input logic [1:0] op);
    return op[0] ? v : {16'h0, v[15:0]};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [3:0]  tag;
  } mreq_t;

  mreq_t       q[$];
  logic        m_ov = 1'b0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_flags = '0;
  logic [3:0]  m_tag = '0;
  logic [3:0]  m_sticky = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare against the model, advance the model by one clock, then step the DUT.
  task automatic cycle();
    mreq_t       h;
    logic [35:0] r;
    bit          can_push, do_pop;
    #1;
    chk("in_ready", in_ready, 32'(q.size() < 2));
    chk("out_valid", out_valid, m_ov);
    chk("out_result", out_result, m_res);
    chk("out_flags", out_flags, m_flags);
    chk("out_tag", out_tag, m_tag);
    chk("sticky", sticky_flags, m_sticky);
    if (q.size() > 0) begin
      chk("fpu_a", fpu_a, lo16(q[0].a, q[0].op));
      chk("fpu_b", fpu_b, lo16(q[0].b, q[0].op));
      chk("fpu_ctrl", fpu_ctrl, q[0].op);
    end else begin
      chk("fpu_idle", {fpu_a ^ fpu_b, fpu_ctrl} == 34'd0 && fpu_a == 32'd0, 32'd1);
    end
    if (!reset) begin
      q.delete();
      m_ov = 0; m_res = '0; m_flags = '0; m_tag = '0; m_sticky = '0;
    end else begin
      can_push = q.size() < 2;
      do_pop   = q.size() > 0 && (!m_ov || out_ready);
      if (do_pop) begin
        h       = q.pop_front();
        r       = fpu_fn(lo16(h.a, h.op), lo16(h.b, h.op), h.op);
        m_res   = lo16(r[31:0], h.op);
        m_flags = r[35:32];
        m_tag   = h.tag;
        m_ov    = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
`ifdef FPU_STICKY_FLAGS_EN
      if (do_pop)            m_sticky = (clear_sticky ? 4'h0 : m_sticky) | r[35:32];
      else if (clear_sticky) m_sticky = 4'h0;
`endif
      if (in_valid && can_push) q.push_back('{a: in_a, b: in_b, op: in_op, tag: in_tag});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    reset = 1'b1;

    // Single add 1.0 + 1.0, one cycle from acceptance to out_valid
    out_ready = 1'b1;
    drive(1, 2'b01, 32'h3F800000, 32'h3F800000, 4'h5);
    cycle();
    drive(0, 2'b00, 0, 0, 0);
    cycle();
    #1;
    chk("r032_valid", out_valid, 1);
    chk("r032_result", out_result, 32'h40000000);
    chk("r032_tag", out_tag, 4'h5);
    cycle();

    // Half add with junk in the upper operand halves
    drive(1, 2'b00, 32'hFFFF3E80, 32'hABCD3800, 4'h6);
    cycle();
    drive(0, 2'b00, 0, 0, 0);
    #1;
    chk("r033_fpu_a", fpu_a, 32'h00003E80);
    chk("r033_fpu_b", fpu_b, 32'h00003800);
    cycle();
    #1;
    chk("r033_result", out_result, 32'h00004040);
    chk("r033_tag", out_tag, 4'h6);
    cycle();

    // Backpressure: three accepts fill result slot plus FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, 32'h3FC00000, 32'h3FC00000, 4'(7 + i));
      cycle();
    end
    #1;
    chk("r034_in_ready", in_ready, 0);
    chk("r034_result", out_result, 32'h40100000);
    chk("r034_tag", out_tag, 4'h7);
    drive(1, 2'b11, 32'h3FC00000, 32'h3FC00000, 4'hA);
    cycle();
    #1;
    chk("r034_hold", {out_valid, out_tag, out_result}, {1'b1, 4'h7, 32'h40100000} & 32'hFFFFFFFF);
    chk("r034_hold_tag", out_tag, 4'h7);
    drive(0, 2'b00, 0, 0, 0);
    out_ready = 1'b1;
    repeat (4) cycle();

    // Five back-to-back requests emerge on consecutive cycles in order
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
      cycle();
      if (i >= 1) begin
        #1;
        chk("r035_valid", out_valid, 1);
        chk("r035_tag", out_tag, 32'(i - 1));
      end
    end
    drive(0, 2'b00, 0, 0, 0);
    cycle();

    // Reset with a full FIFO and a pending result discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, $urandom, $urandom, 4'(i + 1));
      cycle();
    end
    #1;
    chk("r036_full", {in_ready, out_valid}, 2'b01);
    drive(0, 2'b00, 0, 0, 0);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    chk("r036_valid", out_valid, 0);
    chk("r036_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) cycle();

    // Sticky flags: 4 then 2 accumulate, clear coincident with a pop keeps only that pop
    drive(1, 2'b01, 32'h4, 32'h0, 4'h1);
    cycle();
    drive(1, 2'b01, 32'h2, 32'h0, 4'h2);
    cycle();
    drive(1, 2'b01, 32'h1, 32'h0, 4'h3);
    cycle();
    #1;
`ifdef FPU_STICKY_FLAGS_EN
    chk("r037_accum", sticky_flags, 4'h6);
`else
    chk("r037_off", sticky_flags, 4'h0);
`endif
    drive(0, 2'b00, 0, 0, 0);
    clear_sticky = 1'b1;
    cycle();
    #1;
`ifdef FPU_STICKY_FLAGS_EN
    chk("r037_clear_pop", sticky_flags, 4'h1);
`else
    chk("r037_clear_off", sticky_flags, 4'h0);
`endif
    cycle();
    clear_sticky = 1'b0;
    cycle();

    // Random traffic with random backpressure, clears and occasional resets
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom));
      out_ready    = $urandom_range(0, 2) != 0;
      clear_sticky = $urandom_range(0, 9) == 0;
      reset        = $urandom_range(0, 59) != 0;
      cycle();
    end
    reset = 1'b1;
    drive(0, 2'b00, 0, 0, 0);
    out_ready    = 1'b1;
    clear_sticky = 1'b0;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fpu_issue_stage.md
FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: stage accepts a request this cycle.
REQ-005 SHALL have ports in_a and in_b, input, 32 bits each: operands; the low 16 bits carry the operands for half-precision ops.
REQ-006 SHALL have port in_op, input, 2 bits: 00 half add, 01 single add, 10 half mul, 11 single mul.
REQ-007 SHALL have port in_tag, input, 4 bits: opaque request tag.
REQ-008 SHALL have ports fpu_a and fpu_b, output, 32 bits each, and fpu_ctrl, output, 2 bits: drive the combinational fpu.
REQ-009 SHALL have ports fpu_result, input, 32 bits, and fpu_flags, input, 4 bits: returned from the fpu in the same cycle.
REQ-010 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: downstream handshake.
REQ-011 SHALL have ports out_result, output, 32 bits; out_flags, output, 4 bits; and out_tag, output, 4 bits: the registered result.
REQ-012 SHALL have port clear_sticky, input, 1 bit, and port sticky_flags, output, 4 bits.

Function
REQ-013 SHALL hold requests in a 2-entry FIFO; a push occurs when in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready high when and only when the FIFO count is less than 2; in_ready SHALL depend on registered count only, not on out_ready.
REQ-015 SHALL drive fpu_a, fpu_b and fpu_ctrl combinationally from the FIFO head, and SHALL drive them to 0 when the FIFO is empty.
REQ-016 SHALL zero bits 31:16 of fpu_a and fpu_b for ops 00 and 10.
REQ-017 SHALL pop the head when the FIFO is non-empty and (out_valid is low or out_ready is high).
REQ-018 On a pop, SHALL load out_result, out_flags and out_tag with fpu_result, fpu_flags and the head tag, and SHALL set out_valid.
REQ-019 On a pop for ops 00 or 10, SHALL zero bits 31:16 of out_result.
REQ-020 SHALL clear out_valid when out_ready is high and no pop occurs in that cycle.
REQ-021 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-022 Latency SHALL be 1 cycle from acceptance into an empty stage to out_valid; sustained throughput SHALL be 1 per cycle while out_ready is held high.
REQ-023 A push and a pop in the same cycle SHALL leave the count unchanged, and the new entry SHALL be enqueued behind the remaining entries.
REQ-024 SHALL maintain FIFO pointers as 1-bit wrapping indices and the count as 2 bits in the range 0 to 2.
REQ-025 SHALL preserve request order, and SHALL pass the tag through unchanged.

Reset
REQ-026 While reset is low at a rising edge, SHALL set FIFO count and pointers to 0, out_valid to 0, out_result, out_flags and out_tag to 0, and sticky_flags to 0.
REQ-027 A reset mid-operation SHALL discard all queued and unconsumed results without producing any output; in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-028 With FPU_STICKY_FLAGS_EN defined, sticky_flags SHALL OR in fpu_flags on every pop.
REQ-029 With FPU_STICKY_FLAGS_EN defined, clear_sticky high SHALL zero sticky_flags.
REQ-030 With FPU_STICKY_FLAGS_EN defined, when a clear and a pop occur in the same cycle, sticky_flags SHALL equal that pop's fpu_flags.
REQ-031 With FPU_STICKY_FLAGS_EN undefined, sticky_flags SHALL be constant 0, clear_sticky SHALL be ignored, and no sticky register SHALL exist.

Verification
REQ-032 Op 01, a=3F800000, b=3F800000, out_ready=1 -> 1 cycle later out_valid=1, out_result=40000000, tag echoed.
REQ-033 Op 00, a=FFFF3E80, b=ABCD3800 -> fpu_a=00003E80, fpu_b=00003800; out_result=00004040.
REQ-034 Op 11, a=b=3FC00000, out_ready=0 for 3 cycles -> out_result=40100000 held stable; in_ready=0 after 3 accepts.
REQ-035 Stream 5 back-to-back requests with out_ready=1 -> 5 outputs on consecutive cycles, in order, tags 0-4.
REQ-036 Reset low with 2 queued entries and out_valid=1 -> next cycle out_valid=0, in_ready=1; no stale output afterwards.
REQ-037 With FPU_STICKY_FLAGS_EN: flags 4 then 2 -> sticky=6; clear_sticky coincident with a pop of flags 1 -> sticky=1.
